axil_arb2: RTL and testbench

- Two-master to one-slave AXI4-Lite arbiter, placed directly downstream of the core's instruction-fetch and load/store units.
- Merges their memory traffic onto a single memory/peripheral slave port.
- Master 0 is the fetch unit and is read-only. Master 1 is the load/store unit and does reads and writes.
- One transaction is outstanding at a time. Handshakes are passed through under a registered grant.

---
 rtl/axil_arb2_pkg.sv | 18 +
 rtl/axil_arb2_pick.sv | 21 ++
 rtl/axil_arb2.sv | 164 ++++++++++++++++
 tb/tb_axil_arb2.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_arb2_pkg.sv
// Shared types and constants for the two-master AXI4-Lite arbiter.
package axil_arb2_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD0  = 2'd1,
    RD1  = 2'd2,
    WR1  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/axil_arb2_pick.sv
// Combinational grant picker: maps pending requests (and the last read winner) to the next grant state.
module axil_arb2_pick
  import axil_arb2_pkg::*;
(
  input  logic       wr_req,
  input  logic       rd0_req,
  input  logic       rd1_req,
  input  logic       last_grant,
  output arb_state_e next_state
);

  // Writes always win; a read tie goes to the master that did not win last (tied low = fixed m1 priority).
  always_comb begin
    next_state = IDLE;
    if (wr_req)                  next_state = WR1;
    else if (rd0_req && rd1_req) next_state = last_grant ? RD0 : RD1;
    else if (rd1_req)            next_state = RD1;
    else if (rd0_req)            next_state = RD0;
  end

endmodule

// File: rtl/axil_arb2.sv
// axil_arb2: merges fetch (m0, read-only) and load/store (m1) AXI4-Lite masters onto one slave.
// Define AXIL_ARB2_RR_EN for round-robin read arbitration; default build is fixed priority m1 > m0.
module axil_arb2
  import axil_arb2_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   m0_araddr,
  input  logic                m0_arvalid,
  output logic                m0_arready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [1:0]          m0_rresp,
  output logic                m0_rvalid,
  input  logic                m0_rready,
  input  logic [ADDR_W-1:0]   m1_araddr,
  input  logic                m1_arvalid,
  output logic                m1_arready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [1:0]          m1_rresp,
  output logic                m1_rvalid,
  input  logic                m1_rready,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic                m1_awvalid,
  output logic                m1_awready,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_wvalid,
  output logic                m1_wready,
  output logic [1:0]          m1_bresp,
  output logic                m1_bvalid,
  input  logic                m1_bready,
  output logic [ADDR_W-1:0]   s_araddr,
  output logic                s_arvalid,
  input  logic                s_arready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  input  logic                s_rvalid,
  output logic                s_rready,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wvalid,
  input  logic                s_wready,
  input  logic [1:0]          s_bresp,
  input  logic                s_bvalid,
  output logic                s_bready
);

  arb_state_e state;
  arb_state_e pick_state;
  logic       aw_done;
  logic       w_done;
  logic       last_grant;
  logic       b_open;

  axil_arb2_pick u_pick (
    .wr_req     (m1_awvalid | m1_wvalid),
    .rd0_req    (m0_arvalid),
    .rd1_req    (m1_arvalid),
    .last_grant (last_grant),
    .next_state (pick_state)
  );

  assign b_open = aw_done & w_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= pick_state;
        RD0, RD1: begin
          if (s_rvalid && s_rready) state <= IDLE;
        end
        WR1: begin
          if (s_awvalid && s_awready) aw_done <= 1'b1;
          if (s_wvalid && s_wready)   w_done  <= 1'b1;
          if (s_bvalid && s_bready) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AXIL_ARB2_RR_EN
  // s_rready is only ever driven in RD0/RD1, so the R handshake identifies the completing read.
  always_ff @(posedge clk) begin
    if (rst)                        last_grant <= 1'b0;
    else if (s_rvalid && s_rready)  last_grant <= (state == RD1);
  end
`else
  assign last_grant = 1'b0;
`endif

  // Handshake pass-through under the registered grant; everything idles at zero outside its grant.
  always_comb begin
    m0_arready = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = OKAY;
    m0_rvalid  = 1'b0;
    m1_arready = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = OKAY;
    m1_rvalid  = 1'b0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bresp   = OKAY;
    m1_bvalid  = 1'b0;
    s_araddr   = '0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    s_awaddr   = '0;
    s_awvalid  = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    case (state)
      RD0: begin
        s_araddr   = m0_araddr;
        s_arvalid  = m0_arvalid;
        m0_arready = s_arready;
        s_rready   = m0_rready;
        m0_rvalid  = s_rvalid;
        m0_rdata   = s_rdata;
        m0_rresp   = s_rresp;
      end
      RD1: begin
        s_araddr   = m1_araddr;
        s_arvalid  = m1_arvalid;
        m1_arready = s_arready;
        s_rready   = m1_rready;
        m1_rvalid  = s_rvalid;
        m1_rdata   = s_rdata;
        m1_rresp   = s_rresp;
      end
      WR1: begin
        s_awaddr   = m1_awaddr;
        s_awvalid  = m1_awvalid & ~aw_done;
        m1_awready = s_awready & ~aw_done;
        s_wdata    = m1_wdata;
        s_wstrb    = m1_wstrb;
        s_wvalid   = m1_wvalid & ~w_done;
        m1_wready  = s_wready & ~w_done;
        s_bready   = m1_bready & b_open;
        m1_bvalid  = s_bvalid & b_open;
        m1_bresp   = b_open ? s_bresp : OKAY;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axil_arb2.sv
// Randomized bench for axil_arb2: bench-side masters and slave, checked against a grant-order model.
module tb_axil_arb2;
  import axil_arb2_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int K_W  = 0;
  localparam int K_R1 = 1;
  localparam int K_R0 = 2;
`ifdef AXIL_ARB2_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [ADDR_W-1:0] m0_araddr, m1_araddr, m1_awaddr, s_araddr, s_awaddr;
  logic m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
  logic [DATA_W-1:0] m0_rdata, m1_rdata, m1_wdata, s_rdata, s_wdata;
  logic [1:0] m0_rresp, m1_rresp, m1_bresp, s_rresp, s_bresp;
  logic [STRB_W-1:0] m1_wstrb, s_wstrb;
  logic s_arvalid, s_arready, s_rvalid, s_rready;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;

  axil_arb2 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit lg_model = 1'b0;

  // Bench slave state
  bit sl_rpend, sl_bpend, sl_aw, sl_w;
  int sl_rdly, sl_bdly;
  logic [DATA_W-1:0] sl_rdata;
  logic [1:0] sl_rresp, sl_bresp;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [1:0] pick_resp();
    int r;
    r = $urandom_range(0, 2);
    return (r == 0) ? OKAY : (r == 1) ? SLVERR : DECERR;
  endfunction

  function automatic logic any_output();
    return |{m0_arready, m0_rdata, m0_rresp, m0_rvalid, m1_arready, m1_rdata, m1_rresp, m1_rvalid,
             m1_awready, m1_wready, m1_bresp, m1_bvalid, s_araddr, s_arvalid, s_rready,
             s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready};
  endfunction

  task automatic clear_inputs();
    m0_arvalid = 0; m0_rready = 0; m1_arvalid = 0; m1_rready = 0;
    m1_awvalid = 0; m1_wvalid = 0; m1_bready = 0;
    s_arready = 0; s_rvalid = 0; s_awready = 0; s_wready = 0; s_bvalid = 0;
    s_rdata = '0; s_rresp = OKAY; s_bresp = OKAY;
    sl_rpend = 0; sl_bpend = 0; sl_aw = 0; sl_w = 0; sl_rdly = 0; sl_bdly = 0;
  endtask

  task automatic drive_junk();
    m0_arvalid = 0; m1_arvalid = 0; m1_awvalid = 0; m1_wvalid = 0;
    m0_rready = 1; m1_rready = 1; m1_bready = 1;
    s_arready = 1; s_rvalid = 1; s_awready = 1; s_wready = 1; s_bvalid = 1;
    s_rdata = $urandom; s_rresp = SLVERR; s_bresp = DECERR;
  endtask

  // One round: the chosen requests are raised together; the model predicts the service order.
  task automatic run_round(input bit do_wr, input bit do_r1, input bit do_r0, input bit directed);
    int order[$];
    bit pw, p1, p0, sticky, need_first, g0, g1, gw, bok;
    bit h_sar, h_sr, h_saw, h_sw, h_sb, h_m0ar, h_m0r, h_m1ar, h_m1r, h_m1aw, h_m1w, h_m1b;
    int idx, exp_first, gnt, w_wait, recv;
    logic [ADDR_W-1:0] a0, a1, aw, exp_addr;
    logic [DATA_W-1:0] wd;
    logic [STRB_W-1:0] ws;
    logic [11:0] obs, exp;

    pw = do_wr; p1 = do_r1; p0 = do_r0;
    while (pw || p1 || p0) begin
      if (pw) begin order.push_back(K_W); pw = 0; end
      else if (p1 && (!p0 || !lg_model)) begin
        order.push_back(K_R1); p1 = 0; if (RR_EN) lg_model = 1'b1;
      end else begin
        order.push_back(K_R0); p0 = 0; if (RR_EN) lg_model = 1'b0;
      end
    end

    a0 = 32'h8000_0000 + (directed ? 32'h0 : ($urandom & 32'h0000_0FFC));
    a1 = 32'h8001_0000 + (directed ? 32'h100 : ($urandom & 32'h0000_0FFC));
    aw = 32'h8002_0000 + (directed ? 32'h10 : ($urandom & 32'h0000_0FFC));
    wd = directed ? 32'h1234_5678 : $urandom;
    ws = directed ? 4'b0011 : STRB_W'($urandom_range(1, 15));
    w_wait = directed ? 2 : $urandom_range(0, 2);
    sticky = directed ? 1'b0 : 1'($urandom_range(0, 1));

    m0_araddr = a0; m0_arvalid = do_r0;
    m1_araddr = a1; m1_arvalid = do_r1;
    m1_awaddr = aw; m1_awvalid = do_wr;
    m1_wdata = wd; m1_wstrb = ws; m1_wvalid = do_wr && (w_wait == 0);
    if (!do_wr) w_wait = 0;

    idx = 0; recv = 0; need_first = 1; exp_first = cyc + 2;
    for (int t = 0; t < 400 && idx < order.size(); t++) begin
      @(negedge clk); cyc++;
      if (need_first && (s_arvalid || s_awvalid || s_wvalid)) begin
        check_val("grant_latency", 64'(cyc), 64'(exp_first));
        need_first = 0;
      end
      gnt = need_first ? -1 : order[idx];
      g0 = (gnt == K_R0); g1 = (gnt == K_R1); gw = (gnt == K_W); bok = sl_aw && sl_w;
      obs = {s_arvalid, s_rready, m0_arready, m0_rvalid, m1_arready, m1_rvalid,
             s_awvalid, s_wvalid, m1_awready, m1_wready, s_bready, m1_bvalid};
      exp = {(g0 && m0_arvalid) || (g1 && m1_arvalid), (g0 && m0_rready) || (g1 && m1_rready),
             g0 && s_arready, g0 && s_rvalid, g1 && s_arready, g1 && s_rvalid,
             gw && m1_awvalid && !sl_aw, gw && m1_wvalid && !sl_w,
             gw && s_awready && !sl_aw, gw && s_wready && !sl_w,
             gw && bok && m1_bready, gw && bok && s_bvalid};
      check_val("hs_forward", 64'(obs), 64'(exp));

      h_sar = s_arvalid && s_arready;  h_sr = s_rvalid && s_rready;
      h_saw = s_awvalid && s_awready;  h_sw = s_wvalid && s_wready;  h_sb = s_bvalid && s_bready;
      h_m0ar = m0_arvalid && m0_arready;  h_m0r = m0_rvalid && m0_rready;
      h_m1ar = m1_arvalid && m1_arready;  h_m1r = m1_rvalid && m1_rready;
      h_m1aw = m1_awvalid && m1_awready;  h_m1w = m1_wvalid && m1_wready;  h_m1b = m1_bvalid && m1_bready;

      if (h_sar) begin
        exp_addr = (order[idx] == K_R0) ? a0 : (order[idx] == K_R1) ? a1 : ~s_araddr;
        check_val("s_araddr", 64'(s_araddr), 64'(exp_addr));
      end
      if (h_saw) check_val("s_awaddr", 64'(s_awaddr), 64'((order[idx] == K_W) ? aw : ~s_awaddr));
      if (h_sw) check_val("s_wdata_strb", {28'h0, s_wstrb, s_wdata}, {28'h0, ws, wd});
      if (h_m0r) begin
        check_val("m0_rdata", 64'(m0_rdata), 64'(sl_rdata));
        check_val("m0_rresp", 64'(m0_rresp), 64'(sl_rresp));
      end
      if (h_m1r) begin
        check_val("m1_rdata", 64'(m1_rdata), 64'(sl_rdata));
        check_val("m1_rresp", 64'(m1_rresp), 64'(sl_rresp));
      end
      if (h_m1b) check_val("m1_bresp", 64'(m1_bresp), 64'(sl_bresp));
      if (h_m0r || h_m1r || h_m1b) recv++;
      if (h_sr || h_sb) begin
        idx++;
        need_first = (idx < order.size());
        exp_first = cyc + 2;
      end

      @(posedge clk); #1;
      if (h_m0ar) m0_arvalid = 0;
      if (h_m1ar) m1_arvalid = 0;
      if (h_m1aw && !sticky) m1_awvalid = 0;
      if (h_m1w && !sticky) m1_wvalid = 0;
      if (h_m1b) begin m1_awvalid = 0; m1_wvalid = 0; end
      if (w_wait > 0) begin w_wait--; if (w_wait == 0) m1_wvalid = 1; end
      m0_rready = ($urandom_range(0, 3) != 0);
      m1_rready = ($urandom_range(0, 3) != 0);
      m1_bready = ($urandom_range(0, 3) != 0);
      s_arready = 1'($urandom_range(0, 1));
      s_awready = 1'($urandom_range(0, 1));
      s_wready  = 1'($urandom_range(0, 1));

      if (h_sr) begin s_rvalid = 0; sl_rpend = 0; end
      if (h_sb) begin s_bvalid = 0; sl_bpend = 0; sl_aw = 0; sl_w = 0; end
      if (h_sar) begin
        sl_rpend = 1; sl_rdly = $urandom_range(0, 2);
        sl_rdata = directed ? 32'hDEAD_BEEF : $urandom;
        sl_rresp = directed ? OKAY : pick_resp();
      end
      if (h_saw) sl_aw = 1;
      if (h_sw)  sl_w = 1;
      if (sl_aw && sl_w && !sl_bpend) begin
        sl_bpend = 1; sl_bdly = $urandom_range(0, 2);
        sl_bresp = directed ? OKAY : pick_resp();
      end
      if (sl_rpend && !s_rvalid) begin
        if (sl_rdly == 0) begin s_rvalid = 1; s_rdata = sl_rdata; s_rresp = sl_rresp; end
        else sl_rdly--;
      end
      if (sl_bpend && !s_bvalid) begin
        if (sl_bdly == 0) begin s_bvalid = 1; s_bresp = sl_bresp; end
        else sl_bdly--;
      end
    end
    check_val("round_done", 64'(idx), 64'(order.size()));
    check_val("resp_count", 64'(recv), 64'(order.size()));
    clear_inputs();
  endtask

  task automatic reset_mid_write();
    int t;
    m1_awaddr = 32'h8000_0010; m1_awvalid = 1;
    m1_wdata = 32'h1234_5678; m1_wstrb = 4'b0011; m1_wvalid = 0;
    s_awready = 1;
    t = 0;
    do begin
      @(negedge clk); cyc++; t++;
    end while (!(s_awvalid && s_awready) && t < 20);
    check_val("rst_test_aw_hs", 64'(s_awvalid && s_awready), 64'd1);
    @(posedge clk); #1;
    rst = 1; m1_wvalid = 1; s_wready = 1;
    @(posedge clk); #1;
    drive_junk();
    @(negedge clk); cyc++;
    check_val("rst_mid_wr_outputs", 64'(any_output()), 64'd0);
    @(posedge clk); #1;
    rst = 0;
    clear_inputs();
    lg_model = 1'b0;
  endtask

  initial begin
    bit dw, d1, d0;
    m0_araddr = '0; m1_araddr = '0; m1_awaddr = '0; m1_wdata = '0; m1_wstrb = '0;
    clear_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    drive_junk();
    @(negedge clk); cyc++;
    check_val("reset_outputs", 64'(any_output()), 64'd0);
    @(posedge clk); #1;
    clear_inputs();
    rst = 0;
    @(posedge clk); #1;

    run_round(0, 0, 1, 1);
    run_round(0, 1, 1, 1);
    run_round(1, 0, 0, 1);
    run_round(1, 0, 1, 1);
    run_round(1, 1, 1, 0);
    reset_mid_write();
    run_round(0, 0, 1, 1);
    run_round(1, 0, 1, 0);

    for (int i = 0; i < 80; i++) begin
      dw = 1'($urandom_range(0, 1));
      d1 = 1'($urandom_range(0, 1));
      d0 = 1'($urandom_range(0, 1));
      if (!(dw || d1 || d0)) d0 = 1;
      run_round(dw, d1, d0, 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
